button_state_ctrl: RTL and testbench
====================================

Name: button_state_ctrl

Overview:
- Upstream stage of the 4-digit seven-segment display driver on the push-button board.
- Synchronises and debounces two push buttons, POWER and DOOR, and runs the appliance state machine.
- Drives the display driver's 3-bit state code and its one-cycle buzz trigger.
- Runs in the single 50 MHz board clock domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable-level cycles before a button change is accepted (20 ms at 50 MHz); must be >= 2.
- ERR_HOLD_CYCLES, 100_000_000, cycles after ERR entry during which all presses are ignored; matches the display buzzer on-time.
- CNT_W, 27, counter width; must hold max(DEBOUNCE_CYCLES, ERR_HOLD_CYCLES).

Ports:
- clk  input  1  50 MHz board clock
- reset  input  1  synchronous, active-high reset
- btn_power  input  1  raw POWER push button, asynchronous, active-high, bouncy
- btn_door  input  1  raw DOOR push button, asynchronous, active-high, bouncy
- state  output  3  display state code: 000 ERR ("Err"), 001 OFF ("OFF"), 010 ON ("On"), 011 OPEN ("OPEn")
- buzz  output  1  one-cycle pulse that starts the display buzzer
- err_busy  output  1  high while the ERR hold counter is running

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=001 (OFF), buzz=0, err_busy=0.
  - Synchronisers, debounced levels and counters all cleared.
  - Reset mid-debounce or mid-ERR-hold aborts the operation; no pulse is emitted.
- Input path, per button:
  - 2-flop synchroniser.
  - Debouncer: counter restarts whenever the synced level differs from the debounced level. When the synced level has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
  - A press is a 0->1 transition of the debounced level, giving a 1-cycle press pulse. Release generates nothing.
- Latency: raw edge to state change = 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle + 1 register cycle.
- FSM (evaluated on press pulses; registered output):
  - OFF: power -> ON; door -> OPEN.
  - ON: power -> OFF; door -> ERR (door opened while running).
  - OPEN: door -> OFF; power -> ERR (start with door open).
  - ERR: presses ignored while err_busy=1. After that, power -> OFF and door is ignored.
  - Both press pulses in the same cycle, in any non-busy state -> ERR.
  - No press -> hold state.
- ERR entry:
  - buzz=1 for exactly the cycle in which state becomes 000.
  - Hold counter loads ERR_HOLD_CYCLES-1; err_busy=1 until it reaches 0, so err_busy is high for ERR_HOLD_CYCLES cycles.
  - Re-entry into ERR is impossible while busy, so there are no double pulses.
- buzz is never asserted on any other transition.
- Codes 100-111 are never driven. If the state register ever holds one, the next cycle forces OFF.
- A button held continuously produces exactly one press; a second press needs release plus re-press.

Decomposition:
- Shared package:
  - State code constants ST_ERR=3'b000, ST_OFF=3'b001, ST_ON=3'b010, ST_OPEN=3'b011, consumed by the display driver too.
  - Default debounce count.
- Sub-module btn_debounce:
  - Ports clk, reset, raw, level, press.
  - Parameters DEBOUNCE_CYCLES, CNT_W.
  - Instantiated twice.
- FSM, ERR hold counter and buzz logic live in button_state_ctrl.

Test Plan (DEBOUNCE_CYCLES=8, ERR_HOLD_CYCLES=20):
- Reset then idle 50 cycles -> state=001, buzz=0, err_busy=0 throughout.
- btn_power high 40 cycles with 3-cycle bounce pulses at its start -> exactly one transition to 010, exactly 11 cycles after the last bounce edge; release then press again -> back to 001.
- From OFF, door press -> 011; then power press -> 000 with buzz=1 for one cycle only and err_busy=1 for 20 cycles; power press during busy -> stays 000; power press after busy -> 001.
- From ON, 5-cycle glitch on btn_door -> state stays 010, buzz stays 0.
- Both buttons rise on the same cycle from OFF -> state 000 with a single buzz pulse.
- Assert reset during the ERR hold and during a debounce count -> next cycle state=001, err_busy=0, no buzz pulse; a release after reset yields no press.

Source files
------------

// File: rtl/button_state_ctrl_pkg.sv
// Shared definitions for the push-button front end and the seven-segment display driver.
package button_state_ctrl_pkg;

  typedef logic [2:0] state_code_t;

  // Display state codes; 3'b100..3'b111 are never driven.
  localparam state_code_t ST_ERR  = 3'b000;
  localparam state_code_t ST_OFF  = 3'b001;
  localparam state_code_t ST_ON   = 3'b010;
  localparam state_code_t ST_OPEN = 3'b011;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned ERR_HOLD_CYCLES_DEF = 100_000_000;
  localparam int unsigned CNT_W_DEF           = 27;

endpackage

// File: rtl/button_state_ctrl_btn_debounce.sv
// Two-flop synchroniser, level debouncer and registered rising-edge press pulse for one button.
module btn_debounce import button_state_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  // The counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    cnt_d       = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/button_state_ctrl.sv
// Appliance state machine driven by debounced POWER/DOOR presses; feeds the display driver
// with a 3-bit state code, a one-cycle buzz trigger on ERR entry and an ERR-hold busy flag.
module button_state_ctrl import button_state_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned ERR_HOLD_CYCLES = ERR_HOLD_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_power,
  input  logic       btn_door,
  output logic [2:0] state,
  output logic       buzz,
  output logic       err_busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(ERR_HOLD_CYCLES - 1);

  logic pwr_level, pwr_press;
  logic door_level, door_press;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pwr_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_power),
    .level (pwr_level),
    .press (pwr_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_door_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_door),
    .level (door_level),
    .press (door_press)
  );

  // Only press pulses drive the FSM; the debounced levels are not consumed here.
  assign unused_levels = pwr_level ^ door_level;

  state_code_t      state_q, state_d;
  logic             buzz_q, buzz_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pwr, door, err_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      buzz_q  <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      buzz_q  <= buzz_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  // Presses arriving during the ERR hold are dropped before the FSM sees them.
  assign pwr  = pwr_press & ~busy_q;
  assign door = door_press & ~busy_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (pwr && door)  state_d = ST_ERR;
        else if (pwr)     state_d = ST_ON;
        else if (door)    state_d = ST_OPEN;
      end
      ST_ON: begin
        if (pwr && door)  state_d = ST_ERR;
        else if (pwr)     state_d = ST_OFF;
        else if (door)    state_d = ST_ERR;
      end
      ST_OPEN: begin
        if (pwr && door)  state_d = ST_ERR;
        else if (door)    state_d = ST_OFF;
        else if (pwr)     state_d = ST_ERR;
      end
      ST_ERR: begin
        if (pwr && !door) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Buzz and hold counter arm only on entry into ERR, never while already there.
  always_comb begin
    err_entry = (state_d == ST_ERR) && (state_q != ST_ERR);
    buzz_d    = err_entry;
    busy_d    = busy_q;
    hold_d    = hold_q;
    if (err_entry) begin
      busy_d = 1'b1;
      hold_d = HOLD_LOAD;
    end else if (busy_q) begin
      if (hold_q == '0) begin
        busy_d = 1'b0;
      end else begin
        hold_d = hold_q - CNT_W'(1);
      end
    end
  end

  assign state    = state_q;
  assign buzz     = buzz_q;
  assign err_busy = busy_q;

endmodule

// File: tb/tb_button_state_ctrl.sv
// Directed self-checking bench for button_state_ctrl with short debounce and ERR-hold counts.
module tb_button_state_ctrl;
  import button_state_ctrl_pkg::*;

  localparam int unsigned DEB  = 8;
  localparam int unsigned HOLD = 20;

  logic       clk;
  logic       reset;
  logic       btn_power;
  logic       btn_door;
  logic [2:0] state;
  logic       buzz;
  logic       err_busy;

  int checks   = 0;
  int failures = 0;

  int buzz_pulses   = 0;
  int buzz_on_entry = 0;
  int busy_run      = 0;
  int last_busy_run = 0;
  logic [2:0] mon_prev_state = 3'b001;

  button_state_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .ERR_HOLD_CYCLES (HOLD),
    .CNT_W           (27)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_power (btn_power),
    .btn_door  (btn_door),
    .state     (state),
    .buzz      (buzz),
    .err_busy  (err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe buzz and busy shape on the falling edge.
  always @(negedge clk) begin
    if (buzz) buzz_pulses++;
    if (buzz && state == ST_ERR && mon_prev_state != ST_ERR) buzz_on_entry++;
    if (err_busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run      = 0;
    end
    mon_prev_state = state;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 power, 1 door, 2 both
  task automatic press_btn(input int which);
    if (which != 1) btn_power = 1'b1;
    if (which != 0) btn_door  = 1'b1;
    repeat (12) tick();
    btn_power = 1'b0;
    btn_door  = 1'b0;
    repeat (15) tick();
  endtask

  initial begin
    int bad;
    int first_k;
    int changes;
    int b0;
    int e0;
    logic [2:0] prev;

    reset     = 1'b1;
    btn_power = 1'b0;
    btn_door  = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'(ST_OFF));
    chk("rst_buzz", 32'(buzz), 32'd0);
    chk("rst_busy", 32'(err_busy), 32'd0);
    reset = 1'b0;

    bad = 0;
    repeat (50) begin
      tick();
      if (state != ST_OFF || buzz || err_busy) bad++;
    end
    chk("idle", 32'(bad), 32'd0);

    // Bouncy power press: three 3-cycle pulses then a steady high.
    b0 = buzz_pulses;
    repeat (3) begin
      btn_power = 1'b1;
      repeat (3) tick();
      btn_power = 1'b0;
      repeat (3) tick();
    end
    btn_power = 1'b1;
    first_k = -1;
    changes = 0;
    prev    = state;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (state != prev) begin
        changes++;
        if (first_k < 0) first_k = i;
      end
      prev = state;
    end
    btn_power = 1'b0;
    // Edges counted from the first clock edge that samples the final rise.
    chk("bounce_lat", 32'(first_k - 1), 32'd11);
    chk("bounce_changes", 32'(changes), 32'd1);
    chk("bounce_on", 32'(state), 32'(ST_ON));
    repeat (15) tick();
    chk("release_noop", 32'(state), 32'(ST_ON));
    press_btn(0);
    chk("on_to_off", 32'(state), 32'(ST_OFF));
    chk("no_buzz_1", 32'(buzz_pulses - b0), 32'd0);

    press_btn(1);
    chk("off_to_open", 32'(state), 32'(ST_OPEN));

    // Power from OPEN enters ERR; a second press lands inside the hold window.
    b0 = buzz_pulses;
    e0 = buzz_on_entry;
    btn_power = 1'b1;
    repeat (8) tick();
    btn_power = 1'b0;
    repeat (8) tick();
    btn_power = 1'b1;
    repeat (8) tick();
    btn_power = 1'b0;
    repeat (10) tick();
    chk("err_hold_ignore", 32'(state), 32'(ST_ERR));
    chk("busy_done", 32'(err_busy), 32'd0);
    chk("busy_len", 32'(last_busy_run), 32'(HOLD));
    chk("buzz_once", 32'(buzz_pulses - b0), 32'd1);
    chk("buzz_at_entry", 32'(buzz_on_entry - e0), 32'd1);
    press_btn(1);
    chk("err_door_ignored", 32'(state), 32'(ST_ERR));
    press_btn(0);
    chk("err_to_off", 32'(state), 32'(ST_OFF));
    chk("no_buzz_2", 32'(buzz_pulses - b0), 32'd1);

    press_btn(0);
    chk("off_to_on", 32'(state), 32'(ST_ON));
    b0 = buzz_pulses;
    btn_door = 1'b1;
    repeat (5) tick();
    btn_door = 1'b0;
    repeat (20) tick();
    chk("glitch_state", 32'(state), 32'(ST_ON));
    chk("glitch_buzz", 32'(buzz_pulses - b0), 32'd0);

    press_btn(0);
    chk("on_to_off_2", 32'(state), 32'(ST_OFF));
    b0 = buzz_pulses;
    press_btn(2);
    chk("both_err", 32'(state), 32'(ST_ERR));
    chk("both_buzz", 32'(buzz_pulses - b0), 32'd1);
    repeat (20) tick();
    press_btn(0);
    chk("both_recover", 32'(state), 32'(ST_OFF));

    // Reset in the middle of the ERR hold.
    press_btn(1);
    press_btn(0);
    chk("pre_rst_state", 32'(state), 32'(ST_ERR));
    chk("pre_rst_busy", 32'(err_busy), 32'd1);
    b0 = buzz_pulses;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_hold_state", 32'(state), 32'(ST_OFF));
    chk("rst_hold_busy", 32'(err_busy), 32'd0);
    repeat (25) tick();
    chk("rst_hold_buzz", 32'(buzz_pulses - b0), 32'd0);
    chk("rst_hold_stay", 32'(state), 32'(ST_OFF));

    // Reset in the middle of a debounce count, then release.
    btn_power = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    btn_power = 1'b0;
    chk("rst_deb_state", 32'(state), 32'(ST_OFF));
    repeat (25) tick();
    chk("rst_deb_stay", 32'(state), 32'(ST_OFF));
    chk("rst_deb_buzz", 32'(buzz_pulses - b0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
